// File: rtl/jstk_poll_ctrl.sv
// jstk_poll_ctrl
// Periodically polls the PmodJSTK joystick through the `spi` master.
// Each poll raises spi_trigger for TRIG_CYCLES cycles with the 5-byte LED
// command on spi_out_bytes, follows the transfer through spi_cs, and then
// decodes the 40-bit response into X/Y position and button fields.
//
// Ports:
//   clk            in   1   system clock, all logic on posedge
//   rst            in   1   synchronous reset, active-high
//   enable         in   1   polling enabled (sampled in IDLE and GAP only)
//   led            in   2   {led2, led1} to send in the command byte
//   spi_trigger    out  1   to spi.trigger
//   spi_out_bytes  out  40  to spi.out_bytes, byte 0 in [39:32]
//   spi_in_bytes   in   40  from spi.in_bytes, byte 0 in [39:32]
//   spi_cs         in   1   from spi.cs, low while a transfer runs
//   x_pos          out  10  last X sample
//   y_pos          out  10  last Y sample
//   btn            out  3   last buttons {btn2, btn1, jstk}
//   sample_valid   out  1   one-cycle pulse when x_pos/y_pos/btn update
//   timeout_err    out  1   sticky: last poll never saw spi_cs fall
module jstk_poll_ctrl #(
  parameter int unsigned POLL_PERIOD   = 50000,
  parameter int unsigned TRIG_CYCLES   = 5,
  parameter int unsigned START_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  led,
  output logic        spi_trigger,
  output logic [39:0] spi_out_bytes,
  input  logic [39:0] spi_in_bytes,
  input  logic        spi_cs,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [2:0]  btn,
  output logic        sample_valid,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_TRIG       = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_LATCH      = 3'd4,
    ST_GAP        = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(POLL_PERIOD - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              trig_q, trig_d;
  logic [39:0]       out_q, out_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic [2:0]        btn_q, btn_d;
  logic              valid_q, valid_d;
  logic              terr_q, terr_d;
  logic              fell_q, fell_d;   // spi_cs seen low while still in TRIG
  logic [39:0]       cmd_s;
  logic              unused_in_s;

  // LED command: byte 0 = 8'b1000_00{led2,led1}, remaining bytes zero.
  assign cmd_s = {6'b100000, led, 32'h0000_0000};

  // Response bits that carry no joystick information.
  assign unused_in_s = ^{spi_in_bytes[31:26], spi_in_bytes[15:10], spi_in_bytes[7:3]};

  // Next-state and next-output computation for the poll sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
    trig_d  = trig_q;
    out_d   = out_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    valid_d = 1'b0;
    terr_d  = terr_q;
    fell_d  = fell_q;

    case (state_q)
      ST_IDLE: begin
        trig_d = 1'b0;
        // spi may still be finishing a transfer cut short by reset.
        if (enable && spi_cs) begin
          state_d = ST_TRIG;
          cnt_d   = CNT_ZERO;
          trig_d  = 1'b1;
          out_d   = cmd_s;
          fell_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_TRIG: begin
        if (!spi_cs) begin
          fell_d = 1'b1;
        end else begin
          fell_d = fell_q;
        end
        if (cnt_q >= TRIG_LAST) begin
          trig_d = 1'b0;
          // A transfer that already started skips the start wait.
          if (fell_q || !spi_cs) begin
            state_d = ST_WAIT_DONE;
          end else begin
            state_d = ST_WAIT_START;
          end
        end else begin
          trig_d = 1'b1;
        end
      end

      ST_WAIT_START: begin
        trig_d = 1'b0;
        if (!spi_cs) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q >= TMO_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_GAP;
        end else begin
          state_d = ST_WAIT_START;
        end
      end

      ST_WAIT_DONE: begin
        trig_d = 1'b0;
        // Outputs are registered, so the decode is captured on the edge
        // that enters LATCH and is visible throughout the LATCH cycle.
        if (spi_cs) begin
          state_d = ST_LATCH;
          x_d     = {spi_in_bytes[25:24], spi_in_bytes[39:32]};
          y_d     = {spi_in_bytes[9:8], spi_in_bytes[23:16]};
          btn_d   = spi_in_bytes[2:0];
          valid_d = 1'b1;
          terr_d  = 1'b0;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_LATCH: begin
        trig_d  = 1'b0;
        state_d = ST_GAP;
      end

      ST_GAP: begin
        trig_d = 1'b0;
        // Overlong transfers land here with cnt already past the period,
        // so the next poll starts after a single GAP cycle.
        if (cnt_q >= PERIOD_LAST) begin
          if (enable) begin
            state_d = ST_TRIG;
            cnt_d   = CNT_ZERO;
            trig_d  = 1'b1;
            out_d   = cmd_s;
            fell_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_GAP;
        end
      end

      default: begin
        trig_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      trig_q  <= 1'b0;
      out_q   <= 40'h00_0000_0000;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      btn_q   <= 3'd0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
      fell_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      out_q   <= out_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
      valid_q <= valid_d;
      terr_q  <= terr_d;
      fell_q  <= fell_d;
    end
  end

  assign spi_trigger   = trig_q;
  assign spi_out_bytes = out_q;
  assign x_pos         = x_q;
  assign y_pos         = y_q;
  assign btn           = btn_q;
  assign sample_valid  = valid_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// Directed bench for jstk_poll_ctrl. The poll period is set to 2000 so the
// 1024-cycle start timeout fits inside one period.
module tb_jstk_poll_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  led;
  logic        spi_trigger;
  logic [39:0] spi_out_bytes;
  logic [39:0] spi_in_bytes;
  logic        spi_cs;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [2:0]  btn;
  logic        sample_valid;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  jstk_poll_ctrl #(
    .POLL_PERIOD  (2000),
    .TRIG_CYCLES  (5),
    .START_TIMEOUT(1024),
    .CNT_W        (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .led          (led),
    .spi_trigger  (spi_trigger),
    .spi_out_bytes(spi_out_bytes),
    .spi_in_bytes (spi_in_bytes),
    .spi_cs       (spi_cs),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .btn          (btn),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic wait_trig(input string tag, input int max, output int at);
    int k;
    k = 0;
    while (spi_trigger !== 1'b1 && k < max) begin
      tick(1);
      k++;
    end
    chk(tag, {63'd0, spi_trigger}, 64'd1);
    at = cyc;
  endtask

  task automatic no_trig(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (spi_trigger !== 1'b0) seen = 1'b1;
      tick(1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_trig"},  {63'd0, spi_trigger},  64'd0);
    chk({tag, "_out"},   {24'd0, spi_out_bytes}, 64'd0);
    chk({tag, "_x"},     {54'd0, x_pos},        64'd0);
    chk({tag, "_y"},     {54'd0, y_pos},        64'd0);
    chk({tag, "_btn"},   {61'd0, btn},          64'd0);
    chk({tag, "_valid"}, {63'd0, sample_valid}, 64'd0);
    chk({tag, "_terr"},  {63'd0, timeout_err},  64'd0);
  endtask

  initial begin
    int t1, t2, t3, t4, t5, tdummy;
    int hi;
    logic seen;

    rst          = 1'b1;
    enable       = 1'b0;
    spi_cs       = 1'b1;
    led          = 2'b00;
    spi_in_bytes = 40'h00_0000_0000;
    tick(3);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(1);

    // Poll 1: cs low 3 cycles after trigger for 400 cycles.
    led          = 2'b10;
    spi_in_bytes = 40'hA5_03_3C_01_05;
    enable       = 1'b1;
    wait_trig("trig1", 10, t1);
    chk("cmd1", {24'd0, spi_out_bytes}, 64'h82_0000_0000);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      if (spi_trigger === 1'b1) hi++;
      if (k == 3) spi_cs = 1'b0;
      tick(1);
    end
    chk("trig_width", hi, 64'd5);
    tick(92);
    led = 2'b01;                     // mid-transfer change
    tick(303);
    chk("pre_latch_valid", {63'd0, sample_valid}, 64'd0);
    chk("pre_latch_x", {54'd0, x_pos}, 64'd0);
    chk("cmd1_hold", {24'd0, spi_out_bytes}, 64'h82_0000_0000);
    spi_cs = 1'b1;
    tick(1);
    chk("latch1_valid", {63'd0, sample_valid}, 64'd1);
    chk("latch1_x", {54'd0, x_pos}, 64'h3A5);
    chk("latch1_y", {54'd0, y_pos}, 64'h13C);
    chk("latch1_btn", {61'd0, btn}, 64'h5);
    chk("latch1_terr", {63'd0, timeout_err}, 64'd0);
    tick(1);
    chk("valid_pulse_end", {63'd0, sample_valid}, 64'd0);

    // Poll 2: new LED value now in byte 0, short transfer.
    spi_in_bytes = 40'h12_01_F0_02_06;
    wait_trig("trig2", 2000, t2);
    chk("period12", t2 - t1, 64'd2000);
    chk("cmd2", {24'd0, spi_out_bytes}, 64'h81_0000_0000);
    tick(3);
    spi_cs = 1'b0;
    tick(50);
    spi_cs = 1'b1;
    tick(1);
    chk("latch2_valid", {63'd0, sample_valid}, 64'd1);
    chk("latch2_x", {54'd0, x_pos}, 64'h112);
    chk("latch2_y", {54'd0, y_pos}, 64'h2F0);
    chk("latch2_btn", {61'd0, btn}, 64'h6);

    // Poll 3: spi_cs never falls.
    wait_trig("trig3", 2000, t3);
    chk("period23", t3 - t2, 64'd2000);
    tick(1023);
    chk("terr_before", {63'd0, timeout_err}, 64'd0);
    tick(1);
    chk("terr_set", {63'd0, timeout_err}, 64'd1);
    chk("terr_x_hold", {54'd0, x_pos}, 64'h112);
    chk("terr_valid", {63'd0, sample_valid}, 64'd0);

    // Poll 4: still issued on schedule; success clears the error.
    spi_in_bytes = 40'h00_02_FF_03_07;
    wait_trig("trig4", 2000, t4);
    chk("period34", t4 - t3, 64'd2000);
    tick(3);
    spi_cs = 1'b0;
    tick(20);
    chk("terr_sticky", {63'd0, timeout_err}, 64'd1);
    spi_cs = 1'b1;
    tick(1);
    chk("terr_clear", {63'd0, timeout_err}, 64'd0);
    chk("latch4_valid", {63'd0, sample_valid}, 64'd1);
    chk("latch4_x", {54'd0, x_pos}, 64'h200);
    chk("latch4_y", {54'd0, y_pos}, 64'h3FF);
    chk("latch4_btn", {61'd0, btn}, 64'h7);

    // Poll 5: enable dropped during WAIT_DONE.
    wait_trig("trig5", 2000, t5);
    chk("period45", t5 - t4, 64'd2000);
    tick(3);
    spi_cs = 1'b0;
    tick(10);
    enable = 1'b0;
    tick(10);
    spi_cs = 1'b1;
    tick(1);
    chk("latch5_valid", {63'd0, sample_valid}, 64'd1);
    no_trig(4000, seen);
    chk("no_trig_disabled", {63'd0, seen}, 64'd0);

    // Poll 6: reset during WAIT_DONE.
    enable = 1'b1;
    wait_trig("trig6", 5, tdummy);
    tick(3);
    spi_cs = 1'b0;
    tick(20);
    rst = 1'b1;
    tick(1);
    chk_all_zero("rst_mid");
    rst = 1'b0;
    no_trig(50, seen);
    chk("no_trig_cs_low", {63'd0, seen}, 64'd0);
    spi_cs = 1'b1;
    wait_trig("trig_after_cs", 5, tdummy);
    enable = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
